// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared constants and FSM encoding for the frame downscaler
package img_pkg;

    localparam logic MODE_NEAREST = 1'b0;
    localparam logic MODE_AVG     = 1'b1;

    localparam int DEF_IN_W  = 160;
    localparam int DEF_IN_H  = 120;
    localparam int DEF_PIX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/downscale_addr_gen.sv
// rtl/downscale_addr_gen.sv - output pixel and block sample counters with address generation
module downscale_addr_gen
    import img_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int IN_H      = DEF_IN_H,
    parameter int MAX_SHIFT = 2,
    parameter int AW        = $clog2(IN_W*IN_H),
    localparam int SW       = $clog2(MAX_SHIFT+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] shift,
    input  logic          mode,
    input  logic          sample_adv,
    input  logic          pixel_adv,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr,
    output logic          last_sample,
    output logic          last_pixel
);

    localparam int DW = MAX_SHIFT;
    localparam logic [AW-1:0] IN_W_A = AW'(IN_W);
    localparam logic [AW-1:0] IN_H_A = AW'(IN_H);
    localparam logic [AW-1:0] ONE_A  = AW'(1);

    logic [AW-1:0] ox_q, ox_d, oy_q, oy_d, wa_q, wa_d;
    logic [DW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic [DW-1:0] bmax;
    logic [AW-1:0] out_w, out_h, ix, iy;

    always_comb begin
        bmax        = (mode == MODE_AVG) ? DW'((32'd1 << shift) - 32'd1) : '0;
        out_w       = IN_W_A >> shift;
        out_h       = IN_H_A >> shift;
        ix          = (ox_q << shift) + AW'(dx_q);
        iy          = (oy_q << shift) + AW'(dy_q);
        rd_addr     = iy * IN_W_A + ix;
        wr_addr     = wa_q;
        last_sample = (dx_q == bmax) && (dy_q == bmax);
        last_pixel  = (ox_q == out_w - ONE_A) && (oy_q == out_h - ONE_A);
    end

    // All counters wrap to zero after the last pixel, so IDLE always starts from origin.
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        ox_d = ox_q;
        oy_d = oy_q;
        wa_d = wa_q;
        if (sample_adv) begin
            if (dx_q == bmax) begin
                dx_d = '0;
                dy_d = (dy_q == bmax) ? '0 : dy_q + 1'b1;
            end else begin
                dx_d = dx_q + 1'b1;
            end
        end
        if (pixel_adv) begin
            wa_d = last_pixel ? '0 : wa_q + ONE_A;
            if (ox_q == out_w - ONE_A) begin
                ox_d = '0;
                oy_d = (oy_q == out_h - ONE_A) ? '0 : oy_q + ONE_A;
            end else begin
                ox_d = ox_q + ONE_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dx_q <= '0;
            dy_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
            wa_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
            wa_q <= wa_d;
        end
    end

endmodule

// File: rtl/img_downscale.sv
// rtl/img_downscale.sv - power-of-two frame downscaler, nearest or box average
module img_downscale
    import img_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int IN_H      = DEF_IN_H,
    parameter int PIX_W     = DEF_PIX_W,
    parameter int MAX_SHIFT = 2,
    parameter int RD_LAT    = 1,
    parameter int AW        = $clog2(IN_W*IN_H),
    localparam int SW       = $clog2(MAX_SHIFT+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SW-1:0]    shift,
    input  logic             mode,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [PIX_W-1:0] rd_data,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [AW-1:0]    wr_addr,
    output logic [PIX_W-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam int ACC_W = PIX_W + 2*MAX_SHIFT;
    localparam logic [SW-1:0]     MAX_S    = SW'(MAX_SHIFT);
    localparam logic [RD_LAT-1:0] PIPE_TOP = RD_LAT'(1) << (RD_LAT - 1);

    state_t state_q, state_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic              mode_q, mode_d;
    logic              rd_en_q, rd_en_d, wr_valid_q, wr_valid_d;
    logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic              last_iss_q, last_iss_d, last_pix_q, last_pix_d;
    logic              start_ok, ret_valid, more_pending, sample_adv, pixel_adv;
    logic [SW:0]       shamt;
    logic [AW-1:0]     gen_rd_addr, gen_wr_addr;
    logic              gen_last_sample, gen_last_pixel;

    downscale_addr_gen #(
        .IN_W      (IN_W),
        .IN_H      (IN_H),
        .MAX_SHIFT (MAX_SHIFT),
        .AW        (AW)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift       (shift_d),
        .mode        (mode_d),
        .sample_adv  (sample_adv),
        .pixel_adv   (pixel_adv),
        .rd_addr     (gen_rd_addr),
        .wr_addr     (gen_wr_addr),
        .last_sample (gen_last_sample),
        .last_pixel  (gen_last_pixel)
    );

    // Config is fed to the address generator pre-register so the first sample of a frame sees it.
    always_comb begin
        shift_d   = shift_q;
        mode_d    = mode_q;
        start_ok  = 1'b0;
        cfg_err_d = 1'b0;
        if (state_q == ST_IDLE && start) begin
            if (shift > MAX_S) begin
                cfg_err_d = 1'b1;
            end else begin
                start_ok = 1'b1;
                shift_d  = shift;
                mode_d   = mode;
            end
        end
    end

    always_comb begin
        rd_pipe_d    = (rd_pipe_q << 1) | RD_LAT'(rd_en_q);
        ret_valid    = rd_pipe_q[RD_LAT-1];
        more_pending = |(rd_pipe_q & ~PIPE_TOP);
        acc_sum      = acc_q + (ret_valid ? {{(2*MAX_SHIFT){1'b0}}, rd_data} : '0);
        shamt        = (mode_q == MODE_AVG) ? {shift_q, 1'b0} : '0;
    end

    always_comb begin
        state_d    = state_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        acc_d      = acc_sum;
        last_iss_d = last_iss_q;
        last_pix_d = last_pix_q;
        sample_adv = 1'b0;
        pixel_adv  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    busy_d     = 1'b1;
                    state_d    = ST_READ;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = gen_rd_addr;
                    sample_adv = 1'b1;
                    last_iss_d = gen_last_sample;
                end
            end
            ST_READ: begin
                if (last_iss_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_en_d    = 1'b1;
                    rd_addr_d  = gen_rd_addr;
                    sample_adv = 1'b1;
                    last_iss_d = gen_last_sample;
                end
            end
            ST_DRAIN: begin
                // Pixel counters step here so the next block's first read can issue on acceptance.
                if (ret_valid && !more_pending) begin
                    state_d    = ST_WRITE;
                    wr_valid_d = 1'b1;
                    wr_data_d  = PIX_W'(acc_sum >> shamt);
                    wr_addr_d  = gen_wr_addr;
                    last_pix_d = gen_last_pixel;
                    pixel_adv  = 1'b1;
                    acc_d      = '0;
                end
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    wr_valid_d = 1'b0;
                    if (last_pix_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = ST_READ;
                        rd_en_d    = 1'b1;
                        rd_addr_d  = gen_rd_addr;
                        sample_adv = 1'b1;
                        last_iss_d = gen_last_sample;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            mode_q     <= MODE_NEAREST;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            acc_q      <= '0;
            rd_pipe_q  <= '0;
            last_iss_q <= 1'b0;
            last_pix_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            mode_q     <= mode_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            acc_q      <= acc_d;
            rd_pipe_q  <= rd_pipe_d;
            last_iss_q <= last_iss_d;
            last_pix_q <= last_pix_d;
        end
    end

    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_img_downscale.sv
// tb/tb_img_downscale.sv - directed self-checking bench for img_downscale on an 8x4 frame
module tb_img_downscale;

    localparam int IN_W = 8;
    localparam int IN_H = 4;
    localparam int PIX_W = 8;
    localparam int MAX_SHIFT = 2;
    localparam int RD_LAT = 1;
    localparam int AW = 5;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [SW-1:0] shift = '0;
    logic mode = 1'b0;
    logic rd_en;
    logic [AW-1:0] rd_addr;
    logic [PIX_W-1:0] rd_data = '0;
    logic wr_valid;
    logic wr_ready = 1'b1;
    logic [AW-1:0] wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic busy, done, cfg_err;

    int checks = 0;
    int failures = 0;

    int got_addr[64];
    int got_data[64];
    int got_cyc[64];
    int nwr, rd_cnt, done_seen, busy_done, stall_bad, stall_rd, stall_used;
    int stall_addr, stall_data;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= rd_en ? {3'b000, rd_addr} : 8'hEE;

    img_downscale #(
        .IN_W      (IN_W),
        .IN_H      (IN_H),
        .PIX_W     (PIX_W),
        .MAX_SHIFT (MAX_SHIFT),
        .RD_LAT    (RD_LAT),
        .AW        (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .shift    (shift),
        .mode     (mode),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    task automatic run_frame(input int s, input int m, input int stall_at, input int stall_len,
                             input int inj_at, input int max_wr);
        int stall_rem;
        bit first;
        stall_rem = stall_len;
        first = 1'b1;
        nwr = 0; rd_cnt = 0; done_seen = 0; busy_done = 1;
        stall_bad = 0; stall_rd = 0; stall_used = 0; stall_addr = -1; stall_data = -1;
        start = 1'b1; shift = s[SW-1:0]; mode = m[0];
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            start = (cyc == inj_at);
            if (cyc == inj_at) begin
                shift = '0;
                mode = ~mode;
            end
            if (rd_en) rd_cnt++;
            if (wr_valid) begin
                if (nwr == stall_at && stall_rem > 0) begin
                    wr_ready = 1'b0;
                    stall_rem--;
                    stall_used++;
                    if (first) begin
                        stall_addr = int'(wr_addr);
                        stall_data = int'(wr_data);
                        first = 1'b0;
                    end else if (int'(wr_addr) != stall_addr || int'(wr_data) != stall_data) begin
                        stall_bad++;
                    end
                    if (rd_en) stall_rd++;
                end else begin
                    wr_ready = 1'b1;
                    got_addr[nwr] = int'(wr_addr);
                    got_data[nwr] = int'(wr_data);
                    got_cyc[nwr] = cyc;
                    nwr++;
                    if (nwr == max_wr) break;
                end
            end else begin
                wr_ready = 1'b1;
                if (stall_rem < stall_len && stall_rem > 0 && nwr == stall_at) stall_bad++;
            end
            if (done) begin
                done_seen = 1;
                busy_done = int'(busy);
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        wr_ready = 1'b1;
    endtask

    task automatic check_frame(input string name, input int exp_n, input int exp_data[],
                               input int n_samp);
        int bad_gap;
        checks++;
        if (nwr !== exp_n) begin
            failures++;
            $display("FAIL %s count got=%0d exp=%0d", name, nwr, exp_n);
        end
        for (int k = 0; k < exp_n && k < nwr; k++) begin
            checks++;
            if (got_addr[k] !== k || got_data[k] !== exp_data[k]) begin
                failures++;
                $display("FAIL %s pix%0d addr=%0d data=%0d exp addr=%0d data=%0d",
                         name, k, got_addr[k], got_data[k], k, exp_data[k]);
            end
        end
        bad_gap = 0;
        for (int k = 1; k < nwr; k++)
            if (got_cyc[k] - got_cyc[k-1] != n_samp + RD_LAT + 1) bad_gap++;
        checks++;
        if (got_cyc[0] !== n_samp + RD_LAT || bad_gap !== 0) begin
            failures++;
            $display("FAIL %s timing first=%0d exp=%0d bad_gaps=%0d", name, got_cyc[0],
                     n_samp + RD_LAT, bad_gap);
        end
        checks++;
        if (rd_cnt !== exp_n * n_samp) begin
            failures++;
            $display("FAIL %s rd_en count got=%0d exp=%0d", name, rd_cnt, exp_n * n_samp);
        end
        checks++;
        if (done_seen !== 1 || busy_done !== 0) begin
            failures++;
            $display("FAIL %s done=%0d busy_at_done=%0d exp 1 0", name, done_seen, busy_done);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done done=%0b busy=%0b exp 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({rd_en, wr_valid, busy, done, cfg_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {rd_en, wr_valid, busy, done, cfg_err});
        end
        checks++;
        if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
            failures++;
            $display("FAIL reset_data rd_addr=%0d wr_addr=%0d wr_data=%0d exp 0 0 0",
                     rd_addr, wr_addr, wr_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_nearest();
        int e[] = '{0, 2, 4, 6, 16, 18, 20, 22};
        run_frame(1, 0, -1, 0, -1, 1000);
        check_frame("nearest_s1", 8, e, 1);
    endtask

    task automatic test_avg();
        int e1[] = '{4, 6, 8, 10, 20, 22, 24, 26};
        int e2[] = '{13, 17};
        run_frame(1, 1, -1, 0, -1, 1000);
        check_frame("avg_s1", 8, e1, 4);
        run_frame(2, 1, -1, 0, -1, 1000);
        check_frame("avg_s2", 2, e2, 16);
    endtask

    task automatic test_copy();
        int e[] = new[32];
        for (int k = 0; k < 32; k++) e[k] = k;
        run_frame(0, 1, -1, 0, -1, 1000);
        check_frame("copy_avg", 32, e, 1);
        run_frame(0, 0, -1, 0, -1, 1000);
        check_frame("copy_nearest", 32, e, 1);
    endtask

    task automatic test_stall();
        int e[] = '{0, 2, 4, 6, 16, 18, 20, 22};
        run_frame(1, 0, 2, 5, -1, 1000);
        checks++;
        if (stall_used !== 5 || stall_bad !== 0 || stall_rd !== 0) begin
            failures++;
            $display("FAIL stall used=%0d unstable=%0d rd_en=%0d exp 5 0 0",
                     stall_used, stall_bad, stall_rd);
        end
        checks++;
        if (stall_addr !== 2 || stall_data !== 4) begin
            failures++;
            $display("FAIL stall_value addr=%0d data=%0d exp 2 4", stall_addr, stall_data);
        end
        checks++;
        if (got_cyc[3] - got_cyc[2] !== 3) begin
            failures++;
            $display("FAIL stall_resume gap=%0d exp 3", got_cyc[3] - got_cyc[2]);
        end
        got_cyc[2] = got_cyc[1] + 3;
        for (int k = 3; k < 8; k++) got_cyc[k] = got_cyc[k] - 5;
        check_frame("stall", 8, e, 1);
    endtask

    task automatic test_cfg_err();
        int e[] = '{0, 2, 4, 6, 16, 18, 20, 22};
        start = 1'b1; shift = 2'd3; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_pulse cfg_err=%0b busy=%0b rd_en=%0b exp 1 0 0",
                     cfg_err, busy, rd_en);
        end
        @(posedge clk); #1;
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL cfg_err_after cfg_err=%0b busy=%0b rd_en=%0b exp 0 0 0",
                     cfg_err, busy, rd_en);
        end
        run_frame(1, 0, -1, 0, 4, 1000);
        check_frame("start_while_busy", 8, e, 1);
        run_frame(1, 0, -1, 0, -1, 1000);
        start = 1'b1; shift = 2'd1; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done busy=%0b rd_en=%0b exp 0 0", busy, rd_en);
        end
    endtask

    task automatic test_reset_mid();
        int e[] = '{4, 6, 8, 10, 20, 22, 24, 26};
        run_frame(1, 0, -1, 0, -1, 3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({rd_en, wr_valid, busy, done, cfg_err} !== 5'b0 || rd_addr !== '0 ||
            wr_addr !== '0 || wr_data !== '0) begin
            failures++;
            $display("FAIL reset_mid ctrl=%b rd_addr=%0d wr_addr=%0d wr_data=%0d exp all 0",
                     {rd_en, wr_valid, busy, done, cfg_err}, rd_addr, wr_addr, wr_data);
        end
        rst_n = 1'b1;
        run_frame(1, 1, -1, 0, -1, 1000);
        check_frame("after_reset", 8, e, 4);
    endtask

    initial begin
        test_reset();
        test_nearest();
        test_avg();
        test_copy();
        test_stall();
        test_cfg_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/img_downscale.md
Name: img_downscale

Overview:
- Parametrised frame downscaler; successor to the fixed 160x120 nearest-neighbour decimator.
- Reads a packed source frame from the frame-buffer RAM through a fixed-latency read port. Writes the reduced frame linearly through a valid/ready write port.
- Supports a runtime power-of-two factor, nearest-sample or box-average mode, and a start/busy/done handshake.
- Sits between the capture frame buffer and the display/zoom buffer.

Parameters:
- IN_W, 160, source width in pixels. Must be a multiple of 2^MAX_SHIFT.
- IN_H, 120, source height in pixels. Must be a multiple of 2^MAX_SHIFT.
- PIX_W, 8, pixel width in bits.
- MAX_SHIFT, 2, largest supported log2 decimation factor.
- RD_LAT, 1, read latency: cycles from rd_en to valid rd_data (>=1).
- AW, clog2(IN_W*IN_H), address width for both ports.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latches shift and mode.
- shift  in  clog2(MAX_SHIFT+1)  log2 decimation factor s.
- mode  in  1  0 = nearest (top-left sample of block); 1 = box average.
- rd_en  out  1  read strobe.
- rd_addr  out  AW  source address = iy*IN_W + ix.
- rd_data  in  PIX_W  source pixel, valid RD_LAT cycles after rd_en.
- wr_valid  out  1  output pixel valid.
- wr_ready  in  1  sink accepts the pixel.
- wr_addr  out  AW  destination address = oy*OUT_W + ox.
- wr_data  out  PIX_W  output pixel.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last pixel is accepted.
- cfg_err  out  1  one-cycle pulse on an illegal shift.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. rd_en, wr_valid, busy, done and cfg_err are 0. rd_addr, wr_addr and wr_data are 0. Counters and accumulator are cleared. Reset mid-frame aborts immediately; in-flight read data is discarded.
- Output dimensions: OUT_W = IN_W>>s, OUT_H = IN_H>>s. Samples per output pixel: N = 1 in mode 0, 4^s in mode 1.
- FSM states: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE:
  - start with s > MAX_SHIFT: cfg_err=1 for one cycle, remain IDLE.
  - start with a legal s: latch s and mode, busy=1, go to READ.
  - start while busy is ignored.
  - shift and mode changes outside start have no effect.
- READ:
  - Issues one rd_en per cycle for N consecutive cycles.
  - Block offsets dx,dy: dx is inner, dy is outer, each 0..2^s-1. ix = (ox<<s)+dx, iy = (oy<<s)+dy.
  - After the Nth read, go to DRAIN.
- DRAIN:
  - Waits until all N returns have arrived (RD_LAT cycles after the last rd_en).
  - Each returning rd_data is added to the accumulator. Accumulator width is PIX_W+2*MAX_SHIFT; no overflow is possible.
- WRITE:
  - wr_valid=1. wr_data = acc >> (2s), floor, no rounding; in mode 0 this is the single sample.
  - wr_addr, wr_data and wr_valid hold stable until the cycle wr_ready=1.
  - On acceptance: clear acc and advance ox. At ox = OUT_W-1, wrap ox to 0 and increment oy.
  - Then go to READ, or to DONE if this was the last pixel (ox = OUT_W-1, oy = OUT_H-1).
  - No rd_en is issued while in WRITE; there is no overlap between pixels.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start in the DONE cycle is ignored.
- Per-pixel cost with wr_ready tied high: N + RD_LAT + 1 cycles.
- s=0: straight copy, identical in mode 0 and mode 1.
- Registered outputs only; no combinational path from wr_ready to any output.

Decomposition:
- Package img_pkg:
  - mode encoding constants MODE_NEAREST=0, MODE_AVG=1.
  - default IN_W/IN_H/PIX_W.
  - FSM state encoding.
- One sub-module, downscale_addr_gen:
  - holds the ox/oy/dx/dy counters.
  - produces rd_addr, wr_addr, last_sample and last_pixel flags.
  - advance controlled by FSM strobes.
- FSM and accumulator stay in img_downscale.

Test Plan:
Bench uses IN_W=8, IN_H=4, RD_LAT=1, MAX_SHIFT=2, with a RAM model returning rd_data = rd_addr[7:0] and wr_ready=1 unless stated.
1. mode 0, s=1 -> 8 writes, wr_addr 0..7, wr_data 0,2,4,6,16,18,20,22. Then done pulse, busy low. Each pixel takes 3 cycles.
2. mode 1, s=1 -> wr_data 4,6,8,10,20,22,24,26 (floor of a+4.5). Exactly 4 rd_en per pixel.
3. mode 1, s=2 -> 2 writes, wr_data 13,17 (floor of mean over the 4x4 blocks). s=0 -> 32 writes with wr_data=wr_addr.
4. mode 0, s=1, wr_ready low for 5 cycles at the 3rd write -> wr_valid, wr_addr=2 and wr_data=4 stable throughout. No rd_en during the stall. Remaining sequence unchanged.
5. start with shift=3 -> cfg_err pulse, busy stays 0, no rd_en. start during busy -> ignored, frame completes normally.
6. rst_n=0 after the 3rd write of a frame -> all outputs 0 next cycle. A new start produces wr_addr from 0 with correct data.
